tick_generator: RTL and testbench

Multi-channel, runtime-programmable clock-enable/tick generator for the board-level CPU top. It replaces fixed power-of-two dividers. Each channel divides clk by a loadable ratio and emits either a one-cycle tick or a 50%-duty square wave. A global pause/single-step lets the CPU clock be halted and stepped from a board button.

---
 rtl/tick_pkg.sv | 18 +
 rtl/tick_channel.sv | 75 +++++++
 rtl/tick_generator.sv | 77 +++++++
 tb/tick_generator_tb_unused.sv | 1 +
 tb/tb_tick_generator.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_pkg.sv
// Shared definitions for the tick generator: channel output modes and the
// helper used to size the channel-select field.
package tick_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  // Smallest select width (at least 1) that can address n channels.
  function automatic int sel_width(input int n);
    for (int w = 1; w < 31; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 31;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counts 0..div, emits a registered tick on wrap or on a
// forced step, and toggles its square output on each tick in square mode.
module tick_channel
  import tick_pkg::*;
#(
  parameter int              CNT_W       = 24,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             forceTick,
  input  logic             load,
  input  logic [CNT_W-1:0] loadDiv,
  input  logic             loadMode,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  mode_e            mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  // Priority: configuration load, then forced step, then free running.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    cnt_d  = cnt_q;
    div_d  = div_q;
    mode_d = mode_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (load) begin
      div_d  = loadDiv;
      mode_d = mode_e'(loadMode);
      cnt_d  = '0;
      sq_d   = 1'b0;
    end else if (forceTick) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (mode_q == MODE_SQUARE) sq_d = ~sq_q;
    end else if (run) begin
      if (cnt_q == div_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (mode_q == MODE_SQUARE) sq_d = ~sq_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, and every register here is small control state, so all are reset.
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= DEFAULT_DIV;
      mode_q <= MODE_PULSE;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator with global pause and single-step.
// Holds the step edge detector, the write decode and the write status flags.
module tick_generator
  import tick_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 16777215,
  parameter int          SEL_W       = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic              step,
  input  logic              cfgWe,
  input  logic [SEL_W-1:0]  cfgSel,
  input  logic [CNT_W-1:0]  cfgDiv,
  input  logic              cfgMode,
  output logic              cfgAck,
  output logic              cfgErr,
  output logic [NUM_CH-1:0] tickOut,
  output logic [NUM_CH-1:0] clkOut
);

  logic              step_prev_q, step_prev_d;
  logic              cfg_ack_q, cfg_ack_d;
  logic              cfg_err_q, cfg_err_d;
  logic              step_edge;
  logic              sel_ok;
  logic [NUM_CH-1:0] load;

  always_comb begin
    step_prev_d = step;
    step_edge   = step & ~step_prev_q;
    // cfgSel may be wider than needed, so out-of-range indices must be rejected.
    sel_ok      = 32'(cfgSel) < 32'(NUM_CH);
    cfg_ack_d   = cfgWe & sel_ok;
    cfg_err_d   = cfgWe & ~sel_ok;
    load        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = cfgWe && sel_ok && (32'(cfgSel) == 32'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_prev_q <= 1'b0;
      cfg_ack_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      step_prev_q <= step_prev_d;
      cfg_ack_q   <= cfg_ack_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfgAck = cfg_ack_q;
  assign cfgErr = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .run      (~pause),
      .forceTick(step_edge & pause),
      .load     (load[g]),
      .loadDiv  (cfgDiv),
      .loadMode (cfgMode),
      .tick     (tickOut[g]),
      .sq       (clkOut[g])
    );
  end

endmodule

// File: tb/tick_generator_tb_unused.sv


// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: directed scenarios plus a random run,
// all compared against a cycle model of the channel rules.
module tb_tick_generator;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int DEF    = 9;
  localparam int SEL_W  = 2;

  logic              clk = 1'b0;
  logic              reset, pause, step, cfgWe, cfgMode;
  logic [SEL_W-1:0]  cfgSel;
  logic [CNT_W-1:0]  cfgDiv;
  logic              cfgAck, cfgErr;
  logic [NUM_CH-1:0] tickOut, clkOut;

  int vectors = 0;
  int miscompares = 0;

  tick_generator #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .step(step), .cfgWe(cfgWe),
    .cfgSel(cfgSel), .cfgDiv(cfgDiv), .cfgMode(cfgMode), .cfgAck(cfgAck),
    .cfgErr(cfgErr), .tickOut(tickOut), .clkOut(clkOut)
  );

  always #5 clk = ~clk;

  // Reference model state: position within the period, programmed period, outputs.
  int m_cnt [NUM_CH];
  int m_div [NUM_CH];
  bit m_mode[NUM_CH];
  bit m_tick[NUM_CH];
  bit m_sq  [NUM_CH];
  bit m_prev, m_ack, m_err;

  function automatic logic [2*NUM_CH+1:0] exp_vec();
    logic [NUM_CH-1:0] et, es;
    for (int i = 0; i < NUM_CH; i++) begin
      et[i] = m_tick[i];
      es[i] = m_sq[i];
    end
    return {et, es, m_ack, m_err};
  endfunction

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic apply(input bit r, input bit p, input bit s, input bit we,
                       input int sel, input int dv, input bit md);
    bit edge_seen;
    @(negedge clk);
    reset = r; pause = p; step = s; cfgWe = we;
    cfgSel = SEL_W'(sel); cfgDiv = CNT_W'(dv); cfgMode = md;
    if (r) begin
      m_prev = 0; m_ack = 0; m_err = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0; m_div[i] = DEF; m_mode[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
      end
    end else begin
      edge_seen = s && !m_prev;
      m_prev = s;
      m_ack = we && (sel < NUM_CH);
      m_err = we && (sel >= NUM_CH);
      for (int i = 0; i < NUM_CH; i++) begin
        m_tick[i] = 0;
        if (we && sel == i) begin
          m_div[i] = dv; m_mode[i] = md; m_cnt[i] = 0; m_sq[i] = 0;
        end else if (p) begin
          if (edge_seen) begin
            m_cnt[i] = 0; m_tick[i] = 1;
            if (m_mode[i]) m_sq[i] = !m_sq[i];
          end
        end else begin
          m_cnt[i] = (m_cnt[i] + 1) % (m_div[i] + 1);
          if (m_cnt[i] == 0) begin
            m_tick[i] = 1;
            if (m_mode[i]) m_sq[i] = !m_sq[i];
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit p, input bit s);
    apply(0, p, s, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [2*NUM_CH+1:0] got;
    int first_tick;
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if ({tickOut, clkOut, cfgAck, cfgErr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b want=0", {tickOut, clkOut, cfgAck, cfgErr});
    end
    first_tick = -1;
    for (int c = 1; c <= 2 * (DEF + 1) + 2; c++) begin
      idle(0, 0);
      got = {tickOut, clkOut, cfgAck, cfgErr};
      vectors++;
      if (got !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_default_run c=%0d got=%b want=%b", c, got, exp_vec());
      end
      if (first_tick < 0 && tickOut[0]) first_tick = c;
    end
    vectors++;
    if (first_tick != DEF + 1) begin
      miscompares++;
      $display("FAIL default_period got=%0d want=%0d", first_tick, DEF + 1);
    end
  endtask

  task automatic test_pulse_mode();
    logic [2*NUM_CH+1:0] got;
    int n_ticks;
    apply(0, 0, 0, 1, 0, 3, 0);
    vectors++;
    if (cfgAck !== 1'b1 || cfgErr !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_ack got=%b%b want=10", cfgAck, cfgErr);
    end
    n_ticks = 0;
    for (int c = 1; c <= 16; c++) begin
      idle(0, 0);
      got = {tickOut, clkOut, cfgAck, cfgErr};
      vectors++;
      if (got !== exp_vec() || clkOut[0] !== 1'b0 || tickOut[0] !== (c % 4 == 0)) begin
        miscompares++;
        $display("FAIL pulse_run c=%0d got=%b want=%b", c, got, exp_vec());
      end
    end
  endtask

  task automatic test_square_div0();
    logic [2*NUM_CH+1:0] got;
    logic prev_sq;
    apply(0, 0, 0, 1, 1, 0, 1);
    prev_sq = clkOut[1];
    for (int c = 1; c <= 8; c++) begin
      idle(0, 0);
      got = {tickOut, clkOut, cfgAck, cfgErr};
      vectors++;
      if (got !== exp_vec() || tickOut[1] !== 1'b1 || clkOut[1] === prev_sq) begin
        miscompares++;
        $display("FAIL square_div0 c=%0d got=%b want=%b", c, got, exp_vec());
      end
      prev_sq = clkOut[1];
    end
  endtask

  task automatic test_pause();
    logic [2*NUM_CH+1:0] got;
    int guard, wait_cyc;
    guard = 0;
    while (m_cnt[0] != 2 && guard < 10) begin
      idle(0, 0);
      guard++;
    end
    for (int c = 1; c <= 10; c++) begin
      idle(1, 0);
      got = {tickOut, clkOut, cfgAck, cfgErr};
      vectors++;
      if (got !== exp_vec() || tickOut !== '0) begin
        miscompares++;
        $display("FAIL pause_hold c=%0d got=%b want=%b", c, got, exp_vec());
      end
    end
    wait_cyc = 0;
    for (int c = 1; c <= 6 && wait_cyc == 0; c++) begin
      idle(0, 0);
      if (tickOut[0]) wait_cyc = c;
    end
    vectors++;
    if (wait_cyc != 2) begin
      miscompares++;
      $display("FAIL pause_resume_latency got=%0d want=2", wait_cyc);
    end
  endtask

  task automatic test_step();
    logic [2*NUM_CH+1:0] got;
    int n0, n1, wait_cyc;
    idle(1, 0);
    n0 = 0; n1 = 0;
    for (int c = 1; c <= 5; c++) begin
      idle(1, 1);
      got = {tickOut, clkOut, cfgAck, cfgErr};
      vectors++;
      if (got !== exp_vec()) begin
        miscompares++;
        $display("FAIL step_held c=%0d got=%b want=%b", c, got, exp_vec());
      end
      n0 += int'(tickOut[0]);
      n1 += int'(tickOut[1]);
    end
    vectors++;
    if (n0 != 1 || n1 != 1) begin
      miscompares++;
      $display("FAIL step_one_tick got=%0d,%0d want=1,1", n0, n1);
    end
    idle(1, 0);
    wait_cyc = 0;
    for (int c = 1; c <= 8 && wait_cyc == 0; c++) begin
      idle(0, c[0]);
      got = {tickOut, clkOut, cfgAck, cfgErr};
      vectors++;
      if (got !== exp_vec()) begin
        miscompares++;
        $display("FAIL step_running c=%0d got=%b want=%b", c, got, exp_vec());
      end
      if (tickOut[0]) wait_cyc = c;
    end
    vectors++;
    if (wait_cyc != 4) begin
      miscompares++;
      $display("FAIL step_cnt_zero got=%0d want=4", wait_cyc);
    end
  endtask

  task automatic test_cfg_err();
    logic [2*NUM_CH+1:0] got;
    apply(0, 0, 0, 1, 3, 1, 1);
    vectors++;
    if (cfgErr !== 1'b1 || cfgAck !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_flag got=ack%b err%b want=ack0 err1", cfgAck, cfgErr);
    end
    for (int c = 1; c <= 8; c++) begin
      idle(0, 0);
      got = {tickOut, clkOut, cfgAck, cfgErr};
      vectors++;
      if (got !== exp_vec()) begin
        miscompares++;
        $display("FAIL cfg_err_after c=%0d got=%b want=%b", c, got, exp_vec());
      end
    end
  endtask

  task automatic test_wrap_collision();
    int guard, wait_cyc;
    guard = 0;
    while (m_cnt[0] != m_div[0] && guard < 10) begin
      idle(0, 0);
      guard++;
    end
    apply(0, 0, 0, 1, 0, 5, 1);
    vectors++;
    if (tickOut[0] !== 1'b0 || cfgAck !== 1'b1 || {tickOut, clkOut, cfgAck, cfgErr} !== exp_vec()) begin
      miscompares++;
      $display("FAIL wrap_collision got=%b want=%b", {tickOut, clkOut, cfgAck, cfgErr}, exp_vec());
    end
    wait_cyc = 0;
    for (int c = 1; c <= 10 && wait_cyc == 0; c++) begin
      idle(0, 0);
      if (tickOut[0]) wait_cyc = c;
    end
    vectors++;
    if (wait_cyc != 6 || clkOut[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL new_period got=%0d sq=%b want=6 sq=1", wait_cyc, clkOut[0]);
    end
  endtask

  task automatic test_reset_mid();
    int first_tick;
    idle(0, 0);
    idle(0, 0);
    apply(1, 1, 1, 0, 0, 0, 0);
    vectors++;
    if ({tickOut, clkOut, cfgAck, cfgErr} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got=%b want=0", {tickOut, clkOut, cfgAck, cfgErr});
    end
    first_tick = -1;
    for (int c = 1; c <= DEF + 3 && first_tick < 0; c++) begin
      idle(0, 0);
      if (tickOut[1]) first_tick = c;
    end
    vectors++;
    if (first_tick != DEF + 1 || clkOut !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_div got=%0d clk=%b want=%0d clk=0", first_tick, clkOut, DEF + 1);
    end
  endtask

  task automatic test_random();
    logic [2*NUM_CH+1:0] got;
    for (int c = 0; c < 600; c++) begin
      apply($urandom_range(63) == 0, $urandom_range(2) == 0, 1'($urandom),
            $urandom_range(5) == 0, int'($urandom_range(3)),
            int'($urandom_range(6)), 1'($urandom));
      got = {tickOut, clkOut, cfgAck, cfgErr};
      vectors++;
      if (got !== exp_vec()) begin
        miscompares++;
        $display("FAIL random c=%0d got=%b want=%b", c, got, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1; pause = 0; step = 0; cfgWe = 0; cfgSel = '0; cfgDiv = '0; cfgMode = 0;
    test_reset();
    test_pulse_mode();
    test_square_div0();
    test_pause();
    test_step();
    test_cfg_err();
    test_wrap_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
